// File: rtl/frame_dump.sv
// frame_dump: streams the processed image region from memory port b to the UART
// transmit handshake, one 32-bit word at a time, low pixel byte first.
module frame_dump #(
   parameter int WIDTH      = 352,
   parameter int HEIGHT     = 288,
   parameter int BASE_ADDR  = 25344,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [31:0]           mem_dr,
   output logic [7:0]            tx_data,
   output logic                  tx_stb,
   input  logic                  tx_ack
);

   localparam int NWORDS = WIDTH * HEIGHT / 4;
   localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [CNT_W-1:0]      LAST_WORD = CNT_W'(NWORDS - 1);
   localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      SEND,
      DONE
   } state_t;

   state_t           state;
   logic             start_q;
   logic [CNT_W-1:0] word_cnt;
   logic [CNT_W-1:0] word_cnt_next;
   logic [1:0]       idx;
   logic [1:0]       idx_next;
   logic [31:0]      word_q;
   logic             trigger;

   // start_q resets low, so a start already high at reset release is an edge
   assign trigger       = start && !start_q;
   assign idx_next      = idx + 2'd1;
   assign word_cnt_next = word_cnt + CNT_W'(1);
   assign mem_we        = 1'b0;

   // NOTE: all state and outputs update with <=, so every branch below reads
   // the values from before the edge regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         start_q  <= 1'b0;
         word_cnt <= '0;
         idx      <= '0;
         word_q   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         mem_en   <= 1'b0;
         mem_addr <= '0;
         tx_data  <= '0;
         tx_stb   <= 1'b0;
      end else begin
         start_q <= start;
         case (state)
            IDLE: begin
               if (trigger) begin
                  word_cnt <= '0;
                  idx      <= '0;
                  mem_en   <= 1'b1;
                  mem_addr <= BASE;
                  busy     <= 1'b1;
                  state    <= FETCH;
               end
            end
            FETCH: begin
               mem_en <= 1'b0;
               state  <= LOAD;
            end
            LOAD: begin
               word_q  <= mem_dr;
               idx     <= '0;
               tx_data <= mem_dr[7:0];
               tx_stb  <= 1'b1;
               state   <= SEND;
            end
            SEND: begin
               // tx_stb is always high here, so tx_ack alone marks a transfer
               if (tx_ack) begin
                  if (idx != 2'd3) begin
                     idx     <= idx_next;
                     tx_data <= word_q[{idx_next, 3'b000} +: 8];
                  end else begin
                     tx_stb <= 1'b0;
                     if (word_cnt == LAST_WORD) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                     end else begin
                        word_cnt <= word_cnt_next;
                        mem_en   <= 1'b1;
                        mem_addr <= BASE + ADDR_WIDTH'(word_cnt_next);
                        state    <= FETCH;
                     end
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy   <= 1'b0;
               done   <= 1'b0;
               mem_en <= 1'b0;
               tx_stb <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_dump.sv
// tb_frame_dump: randomized self-checking bench for frame_dump, comparing the
// transmitted byte stream and read addresses against a memory/byte-order model.
`timescale 1ns/1ps
module tb_frame_dump;

   localparam int S_W = 4, S_H = 2, S_BASE = 16;
   localparam int B_W = 352, B_H = 16, B_BASE = 64128;
   localparam int B_NW = B_W * B_H / 4;
   localparam int D_BASE = 25344;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] mem_seed;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Memory contents model: two fixed words for the small frame, pseudo-random elsewhere
   function automatic logic [31:0] mem_f(input logic [15:0] a);
      if (a == 16'd16) return 32'h44332211;
      if (a == 16'd17) return 32'h88776655;
      return {a, ~a} ^ mem_seed;
   endfunction

   // k-th byte of a dump starting at word address base, low byte of each word first
   function automatic logic [7:0] exp_byte(input int base, input int k);
      logic [31:0] w;
      w = mem_f(16'(base + k / 4));
      return 8'(w >> (8 * (k % 4)));
   endfunction

   // ---------------- small frame DUT ----------------
   logic        s_rst = 1'b0, s_start = 1'b0;
   logic        s_busy, s_done, s_mem_en, s_mem_we, s_tx_stb, s_tx_ack;
   logic [15:0] s_mem_addr;
   logic [31:0] s_mem_dr = '0;
   logic [7:0]  s_tx_data;
   logic        s_ack_tie = 1'b0, s_ack_r = 1'b0;
   int          s_delay = 0;

   frame_dump #(.WIDTH(S_W), .HEIGHT(S_H), .BASE_ADDR(S_BASE), .ADDR_WIDTH(16)) u_small (
      .clk(clk), .rst(s_rst), .start(s_start), .busy(s_busy), .done(s_done),
      .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_dr(s_mem_dr),
      .tx_data(s_tx_data), .tx_stb(s_tx_stb), .tx_ack(s_tx_ack)
   );

   always @(posedge clk) if (s_mem_en) s_mem_dr <= mem_f(s_mem_addr);
   assign s_tx_ack = s_ack_tie ? s_tx_stb : s_ack_r;

   // Random acknowledge: 0-20 cycle delay per byte, random noise while tx_stb is low
   always @(posedge clk) begin
      #1;
      if (!s_tx_stb) s_ack_r = 1'($urandom_range(0, 1));
      else if (s_delay > 0) begin
         s_ack_r = 1'b0;
         s_delay--;
      end else begin
         s_ack_r = 1'b1;
         s_delay = $urandom_range(0, 20);
      end
   end

   logic [7:0]  s_bytes[$];
   logic [15:0] s_addrs[$];
   int          s_dones = 0, s_unstable = 0, s_busy_at_done = 0;
   logic        s_stb_prev = 1'b0, s_ack_prev = 1'b0;
   logic [7:0]  s_data_prev = '0;

   always @(negedge clk) begin
      if (s_rst) s_stb_prev = 1'b0;
      else begin
         if (s_stb_prev && !s_ack_prev && (!s_tx_stb || s_tx_data !== s_data_prev)) s_unstable++;
         if (s_tx_stb && s_tx_ack) s_bytes.push_back(s_tx_data);
         if (s_mem_en) s_addrs.push_back(s_mem_addr);
         if (s_done) begin
            s_dones++;
            if (s_busy) s_busy_at_done++;
         end
         s_stb_prev  = s_tx_stb;
         s_ack_prev  = s_tx_ack;
         s_data_prev = s_tx_data;
      end
   end

   task automatic s_clear();
      s_bytes.delete();
      s_addrs.delete();
      s_dones        = 0;
      s_unstable     = 0;
      s_busy_at_done = 0;
   endtask

   task automatic s_wait_dones(input int target, input int budget, input string tag);
      int i = 0;
      while (s_dones < target && i < budget) begin
         @(negedge clk);
         i++;
      end
      check({tag, " done within budget"}, 32'(s_dones >= target), 32'd1);
   endtask

   task automatic s_check_frame(input string tag);
      check({tag, " byte count"}, s_bytes.size(), 8);
      for (int k = 0; k < s_bytes.size() && k < 8; k++)
         check($sformatf("%s byte%0d", tag, k), 32'(s_bytes[k]), 32'(exp_byte(S_BASE, k)));
      check({tag, " read count"}, s_addrs.size(), 2);
      for (int k = 0; k < s_addrs.size() && k < 2; k++)
         check($sformatf("%s read%0d", tag, k), 32'(s_addrs[k]), S_BASE + k);
      check({tag, " done pulses"}, s_dones, 1);
      check({tag, " busy during done"}, s_busy_at_done, 0);
      check({tag, " data held while stalled"}, s_unstable, 0);
   endtask

   // ---------------- wide frame DUT (352 wide, ends at the top address) ----------------
   logic        b_rst = 1'b0, b_start = 1'b1;
   logic        b_busy, b_done, b_mem_en, b_mem_we, b_tx_stb, b_tx_ack;
   logic [15:0] b_mem_addr, b_last_addr = '0;
   logic [31:0] b_mem_dr = '0;
   logic [7:0]  b_tx_data;
   int          b_nbytes = 0, b_nreads = 0, b_bad = 0, b_addr_bad = 0, b_dones = 0, b_bytes_at_done = -1;

   frame_dump #(.WIDTH(B_W), .HEIGHT(B_H), .BASE_ADDR(B_BASE), .ADDR_WIDTH(16)) u_wide (
      .clk(clk), .rst(b_rst), .start(b_start), .busy(b_busy), .done(b_done),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_dr(b_mem_dr),
      .tx_data(b_tx_data), .tx_stb(b_tx_stb), .tx_ack(b_tx_ack)
   );

   always @(posedge clk) if (b_mem_en) b_mem_dr <= mem_f(b_mem_addr);
   assign b_tx_ack = b_tx_stb;

   always @(negedge clk) begin
      if (!b_rst) begin
         if (b_tx_stb && b_tx_ack) begin
            if (b_tx_data !== exp_byte(B_BASE, b_nbytes)) b_bad++;
            b_nbytes++;
         end
         if (b_mem_en) begin
            if (b_mem_addr !== 16'(B_BASE + b_nreads)) b_addr_bad++;
            b_last_addr = b_mem_addr;
            b_nreads++;
         end
         if (b_done) begin
            b_dones++;
            b_bytes_at_done = b_nbytes;
         end
      end
   end

   // ---------------- default-parameter DUT ----------------
   logic        d_rst = 1'b0, d_start = 1'b0;
   logic        d_busy, d_done, d_mem_en, d_mem_we, d_tx_stb, d_tx_ack;
   logic [15:0] d_mem_addr;
   logic [31:0] d_mem_dr = '0;
   logic [7:0]  d_tx_data;

   frame_dump u_dflt (
      .clk(clk), .rst(d_rst), .start(d_start), .busy(d_busy), .done(d_done),
      .mem_en(d_mem_en), .mem_we(d_mem_we), .mem_addr(d_mem_addr), .mem_dr(d_mem_dr),
      .tx_data(d_tx_data), .tx_stb(d_tx_stb), .tx_ack(d_tx_ack)
   );

   always @(posedge clk) if (d_mem_en) d_mem_dr <= mem_f(d_mem_addr);
   assign d_tx_ack = d_tx_stb;

   // ---------------- stimulus ----------------
   initial begin
      int lat_fetch, lat_stb, lat_done, act, cnt, i, nb, nr;
      mem_seed = $urandom;

      // Reset with random inputs
      #3;
      s_rst = 1'b1;
      b_rst = 1'b1;
      d_rst = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         s_start = 1'($urandom_range(0, 1));
      end
      check("reset busy", 32'(s_busy), 0);
      check("reset done", 32'(s_done), 0);
      check("reset mem_en", 32'(s_mem_en), 0);
      check("reset mem_we", 32'(s_mem_we), 0);
      check("reset mem_addr", 32'(s_mem_addr), 0);
      check("reset tx_stb", 32'(s_tx_stb), 0);
      check("reset tx_data", 32'(s_tx_data), 0);
      s_start = 1'b0;
      @(negedge clk);
      s_rst = 1'b0;
      d_rst = 1'b0;
      act = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (s_busy || s_done || s_mem_en || s_tx_stb) act++;
      end
      check("idle after reset activity", act, 0);
      check("idle after reset bytes", s_bytes.size(), 0);

      // Small frame, immediate ack; start stays high so it must not retrigger
      s_clear();
      s_ack_tie = 1'b1;
      s_start   = 1'b1;
      lat_fetch = -1;
      lat_stb   = -1;
      lat_done  = -1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (s_mem_en && lat_fetch < 0) lat_fetch = n;
         if (s_tx_stb && lat_stb < 0) lat_stb = n;
         if (s_done && lat_done < 0) lat_done = n;
      end
      s_start = 1'b0;
      check("fetch latency", lat_fetch, 1);
      check("first tx_stb latency", lat_stb, 3);
      check("done latency", lat_done, 13);
      s_check_frame("immediate");

      // Backpressure
      s_clear();
      s_ack_tie = 1'b0;
      @(negedge clk);
      s_start = 1'b1;
      s_wait_dones(1, 2000, "backpressure");
      s_start = 1'b0;
      repeat (10) @(negedge clk);
      s_check_frame("backpressure");

      // Start misuse: second edge during SEND, then held high through done
      s_clear();
      @(negedge clk);
      s_start = 1'b1;
      i = 0;
      while (!s_tx_stb && i < 20) begin
         @(negedge clk);
         i++;
      end
      check("misuse reached send", 32'(s_tx_stb), 1);
      s_start = 1'b0;
      @(negedge clk);
      s_start = 1'b1;
      s_wait_dones(1, 2000, "misuse");
      repeat (30) @(negedge clk);
      s_check_frame("misuse");
      s_clear();
      s_start = 1'b0;
      @(negedge clk);
      s_start = 1'b1;
      s_wait_dones(1, 2000, "replay");
      s_start = 1'b0;
      repeat (10) @(negedge clk);
      s_check_frame("replay");

      // Reset after the third acknowledged byte
      s_clear();
      @(negedge clk);
      s_start = 1'b1;
      cnt = 0;
      i   = 0;
      while (cnt < 3 && i < 2000) begin
         @(negedge clk);
         if (s_tx_stb && s_tx_ack) cnt++;
         i++;
      end
      check("mid-frame reached third ack", cnt, 3);
      @(posedge clk);
      #2;
      s_rst = 1'b1;
      #1;
      check("mid reset tx_stb", 32'(s_tx_stb), 0);
      check("mid reset mem_en", 32'(s_mem_en), 0);
      check("mid reset busy", 32'(s_busy), 0);
      s_start = 1'b0;
      repeat (2) @(negedge clk);
      s_rst = 1'b0;
      s_clear();
      s_ack_tie = 1'b1;
      @(negedge clk);
      s_start = 1'b1;
      s_wait_dones(1, 100, "after reset");
      s_start = 1'b0;
      repeat (10) @(negedge clk);
      check("after reset first byte", s_bytes.size() > 0 ? 32'(s_bytes[0]) : 32'hffff_ffff, 32'h11);
      s_check_frame("after reset");

      // Wide frame: start was high through reset, so release alone triggers
      b_rst = 1'b0;
      i = 0;
      while (b_dones < 1 && i < 20000) begin
         @(negedge clk);
         i++;
      end
      b_start = 1'b0;
      repeat (10) @(negedge clk);
      check("wide done within budget", 32'(b_dones >= 1), 1);
      check("wide byte count", b_nbytes, B_NW * 4);
      check("wide byte mismatches", b_bad, 0);
      check("wide read count", b_nreads, B_NW);
      check("wide address errors", b_addr_bad, 0);
      check("wide last read address", 32'(b_last_addr), 65535);
      check("wide done pulses", b_dones, 1);
      check("wide bytes before done", b_bytes_at_done, B_NW * 4);

      // Default parameters: first two words only, then abort with reset
      @(negedge clk);
      d_start = 1'b1;
      nb = 0;
      nr = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (d_mem_en) begin
            if (nr < 2) check($sformatf("default read%0d", nr), 32'(d_mem_addr), D_BASE + nr);
            nr++;
         end
         if (d_tx_stb && d_tx_ack) begin
            if (nb < 8) check($sformatf("default byte%0d", nb), 32'(d_tx_data), 32'(exp_byte(D_BASE, nb)));
            nb++;
         end
      end
      check("default reads seen", 32'(nr >= 2), 1);
      check("default bytes seen", 32'(nb >= 8), 1);
      d_rst = 1'b1;
      #1;
      check("default abort tx_stb", 32'(d_tx_stb), 0);
      check("default abort busy", 32'(d_busy), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
